// File: rtl/des_align_ctrl.sv
// des_align_ctrl
// Word-alignment controller for the deserializer tree output. Rotates each
// W-bit word by a slip offset (bit 0 earliest) and runs an offset search
// against a training pattern until lock, then optionally monitors alignment
// and re-searches on persistent mismatches.
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_en                  run alignment FSM (0 forces IDLE)
//   i_valid, i_dat        input word strobe and data
//   i_pattern             training pattern
//   i_mon_en              check pattern while LOCKED
//   o_dat, o_valid        aligned word, 1-cycle latency
//   o_offset              current slip offset
//   o_locked, o_fail      state decodes
//   o_state               IDLE=0 SETTLE=1 CHECK=2 SLIP=3 LOCKED=4 FAIL=5
//   o_err_cnt             saturating mismatch count while LOCKED
module des_align_ctrl #(
    parameter int unsigned Width        = 16,
    parameter int unsigned SettleCycles = 4,
    parameter int unsigned LockCount    = 8,
    parameter int unsigned ErrThresh    = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic                     i_valid,
    input  logic [Width-1:0]         i_dat,
    input  logic [Width-1:0]         i_pattern,
    input  logic                     i_mon_en,
    output logic [Width-1:0]         o_dat,
    output logic                     o_valid,
    output logic [$clog2(Width)-1:0] o_offset,
    output logic                     o_locked,
    output logic                     o_fail,
    output logic [2:0]               o_state,
    output logic [7:0]               o_err_cnt
);

    localparam int unsigned OW  = $clog2(Width);
    localparam int unsigned SLW = $clog2(Width + 1);
    localparam int unsigned STW = $clog2(SettleCycles + 1);
    localparam int unsigned MCW = $clog2(LockCount + 1);
    localparam int unsigned CEW = $clog2(ErrThresh + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_CHECK  = 3'd2;
    localparam logic [2:0] S_SLIP   = 3'd3;
    localparam logic [2:0] S_LOCKED = 3'd4;
    localparam logic [2:0] S_FAIL   = 3'd5;

    logic [2:0]       state_q,      state_d;
    logic [Width-1:0] prev_q,       prev_d;
    logic [Width-1:0] dat_q,        dat_d;
    logic             valid_q,      valid_d;
    logic [OW-1:0]    offset_q,     offset_d;
    logic             locked_q,     locked_d;
    logic             fail_q,       fail_d;
    logic [7:0]       err_cnt_q,    err_cnt_d;
    logic [STW-1:0]   settle_cnt_q, settle_cnt_d;
    logic [MCW-1:0]   match_cnt_q,  match_cnt_d;
    logic [SLW-1:0]   slip_cnt_q,   slip_cnt_d;
    logic [CEW-1:0]   cerr_cnt_q,   cerr_cnt_d;

    logic [2*Width-1:0] shifted;
    logic [Width-1:0]   aligned;
    logic               match;
    logic [OW-1:0]      offset_inc;

    // Offset k selects stream bits k..k+W-1; the previous word supplies LSBs.
    assign shifted = {i_dat, prev_q} >> offset_q;
    assign aligned = shifted[Width-1:0];
    assign match   = (aligned == i_pattern);

    // Explicit wrap so non-power-of-2 widths never reach an invalid offset.
    assign offset_inc = (offset_q == OW'(Width - 1)) ? '0 : offset_q + OW'(1);

    // Next-state, datapath and counters.
    always_comb begin
        state_d      = state_q;
        prev_d       = i_valid ? i_dat : prev_q;
        dat_d        = i_valid ? aligned : dat_q;
        valid_d      = i_valid;
        offset_d     = offset_q;
        err_cnt_d    = err_cnt_q;
        settle_cnt_d = settle_cnt_q;
        match_cnt_d  = match_cnt_q;
        slip_cnt_d   = slip_cnt_q;
        cerr_cnt_d   = cerr_cnt_q;

        if (!i_en) begin
            state_d      = S_IDLE;
            settle_cnt_d = '0;
            match_cnt_d  = '0;
            slip_cnt_d   = '0;
            cerr_cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d      = S_SETTLE;
                    settle_cnt_d = '0;
                    match_cnt_d  = '0;
                    slip_cnt_d   = '0;
                end
                S_SETTLE: begin
                    if (i_valid) begin
                        if (settle_cnt_q == STW'(SettleCycles - 1)) begin
                            state_d      = S_CHECK;
                            settle_cnt_d = '0;
                            match_cnt_d  = '0;
                        end else begin
                            settle_cnt_d = settle_cnt_q + STW'(1);
                        end
                    end
                end
                S_CHECK: begin
                    if (i_valid) begin
                        if (match) begin
                            if (match_cnt_q == MCW'(LockCount - 1)) begin
                                state_d     = S_LOCKED;
                                match_cnt_d = '0;
                                cerr_cnt_d  = '0;
                            end else begin
                                match_cnt_d = match_cnt_q + MCW'(1);
                            end
                        end else begin
                            match_cnt_d = '0;
                            state_d     = S_SLIP;
                        end
                    end
                end
                S_SLIP: begin
                    offset_d   = offset_inc;
                    slip_cnt_d = slip_cnt_q + SLW'(1);
                    if (slip_cnt_q == SLW'(Width - 1)) begin
                        state_d = S_FAIL;
                    end else begin
                        state_d      = S_SETTLE;
                        settle_cnt_d = '0;
                    end
                end
                S_LOCKED: begin
                    if (i_valid && i_mon_en) begin
                        if (match) begin
                            cerr_cnt_d = '0;
                        end else begin
                            if (err_cnt_q != 8'hFF) begin
                                err_cnt_d = err_cnt_q + 8'd1;
                            end
                            if (cerr_cnt_q == CEW'(ErrThresh - 1)) begin
                                // Lock lost: start a fresh full search.
                                state_d    = S_SLIP;
                                slip_cnt_d = '0;
                                cerr_cnt_d = '0;
                            end else begin
                                cerr_cnt_d = cerr_cnt_q + CEW'(1);
                            end
                        end
                    end
                end
                S_FAIL:  state_d = S_FAIL;
                default: state_d = S_IDLE;
            endcase
        end

        locked_d = (state_d == S_LOCKED);
        fail_d   = (state_d == S_FAIL);
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            prev_q       <= '0;
            dat_q        <= '0;
            valid_q      <= 1'b0;
            offset_q     <= '0;
            locked_q     <= 1'b0;
            fail_q       <= 1'b0;
            err_cnt_q    <= '0;
            settle_cnt_q <= '0;
            match_cnt_q  <= '0;
            slip_cnt_q   <= '0;
            cerr_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            dat_q        <= dat_d;
            valid_q      <= valid_d;
            offset_q     <= offset_d;
            locked_q     <= locked_d;
            fail_q       <= fail_d;
            err_cnt_q    <= err_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            match_cnt_q  <= match_cnt_d;
            slip_cnt_q   <= slip_cnt_d;
            cerr_cnt_q   <= cerr_cnt_d;
        end
    end

    assign o_dat     = dat_q;
    assign o_valid   = valid_q;
    assign o_offset  = offset_q;
    assign o_locked  = locked_q;
    assign o_fail    = fail_q;
    assign o_state   = state_q;
    assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_des_align_ctrl.sv
// tb_des_align_ctrl
// Directed bench for des_align_ctrl (W=16): reset values, valid gaps during
// settle/check, reset mid-search, offset search and lock, lock loss, offset
// wrap 15->0, and exhaustive-search failure. Aligned output words are
// predicted by a stream model and checked through a scoreboard queue.
module tb_des_align_ctrl;

    localparam int unsigned W  = 16;
    localparam int unsigned OW = 4;
    localparam logic [15:0] PAT     = 16'h00FF;
    localparam logic [15:0] ROT5    = 16'h1FE0;
    localparam logic [15:0] ROT5BAD = 16'h1FFF;
    localparam logic [15:0] ROT15   = 16'h807F;
    localparam logic [15:0] NOMATCH = 16'hFFFF;

    logic          clk = 1'b0;
    logic          i_rst_n, i_en, i_valid, i_mon_en;
    logic [W-1:0]  i_dat, i_pattern;
    logic [W-1:0]  o_dat;
    logic          o_valid, o_locked, o_fail;
    logic [OW-1:0] o_offset;
    logic [2:0]    o_state;
    logic [7:0]    o_err_cnt;

    always #5 clk = ~clk;

    des_align_ctrl #(.Width(16), .SettleCycles(4), .LockCount(8), .ErrThresh(4)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_valid(i_valid),
        .i_dat(i_dat), .i_pattern(i_pattern), .i_mon_en(i_mon_en),
        .o_dat(o_dat), .o_valid(o_valid), .o_offset(o_offset),
        .o_locked(o_locked), .o_fail(o_fail), .o_state(o_state),
        .o_err_cnt(o_err_cnt)
    );

    int          errors = 0;
    int          checks = 0;
    logic [15:0] sb_q[$];
    bit          sb_on = 1'b0;
    logic [15:0] m_prev = '0;
    logic [15:0] m_last = '0;
    int          m_off = 0;
    int          slips;
    bit          hit;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive a word, predict its aligned value, check after the edge.
    task automatic step(input logic v, input logic [15:0] d);
        logic [31:0] cat;
        logic [15:0] e;
        logic [15:0] got;
        @(negedge clk);
        i_valid = v;
        i_dat   = d;
        cat = {d, m_prev} >> m_off;
        e   = cat[15:0];
        if (v) begin
            if (sb_on) begin
                sb_q.push_back(e);
                m_last = e;
            end
            m_prev = d;
        end
        @(posedge clk);
        #1;
        chk("o_valid", 32'(o_valid), 32'(v));
        if (sb_on) begin
            if (v) begin
                if (sb_q.size() != 0) begin
                    got = sb_q.pop_front();
                    chk("o_dat", 32'(o_dat), 32'(got));
                end
            end else begin
                chk("o_dat_hold", 32'(o_dat), 32'(m_last));
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        @(posedge clk);
        #1;
        sb_q.delete();
        m_prev = '0;
        m_last = '0;
        chk("rst_dat",    32'(o_dat),     32'h0);
        chk("rst_valid",  32'(o_valid),   32'h0);
        chk("rst_offset", 32'(o_offset),  32'h0);
        chk("rst_locked", 32'(o_locked),  32'h0);
        chk("rst_fail",   32'(o_fail),    32'h0);
        chk("rst_state",  32'(o_state),   32'h0);
        chk("rst_errcnt", 32'(o_err_cnt), 32'h0);
        i_rst_n = 1'b1;
    endtask

    // Stream words until lock (or fail), counting SLIP visits.
    task automatic run_until(input logic [15:0] d, input int max, input bit want_fail,
                             output int n_slip, output bit reached);
        n_slip  = 0;
        reached = 1'b0;
        for (int n = 0; n < max && !reached; n++) begin
            step(1'b1, d);
            if (o_state == 3'd3) n_slip++;
            reached = want_fail ? o_fail : o_locked;
        end
    endtask

    initial begin
        i_rst_n = 1'b0; i_en = 1'b0; i_valid = 1'b0; i_mon_en = 1'b0;
        i_dat = '0; i_pattern = PAT;
        do_reset();

        // Valid gaps during SETTLE/CHECK; only valid words count.
        sb_on = 1'b1; m_off = 0;
        i_en = 1'b1;
        step(1'b0, ROT5);  chk("gap_settle0", 32'(o_state), 32'd1);
        step(1'b1, ROT5);  step(1'b0, ROT5);
        step(1'b1, ROT5);  step(1'b0, ROT5);
        step(1'b1, ROT5);  chk("gap_settle3", 32'(o_state), 32'd1);
        step(1'b0, ROT5);  chk("gap_settle_idle", 32'(o_state), 32'd1);
        step(1'b1, ROT5);  chk("gap_to_check", 32'(o_state), 32'd2);
        step(1'b0, ROT5);  chk("gap_check_hold", 32'(o_state), 32'd2);
        step(1'b1, ROT5);  chk("gap_to_slip", 32'(o_state), 32'd3);
        step(1'b0, ROT5);  chk("gap_slip_settle", 32'(o_state), 32'd1);
        chk("gap_offset1", 32'(o_offset), 32'd1);
        m_off = 1;
        for (int i = 0; i < 4; i++) step(1'b1, ROT5);
        chk("gap_check2", 32'(o_state), 32'd2);

        // Reset mid-CHECK.
        do_reset();

        // Search from offset 0 to the 5-bit-late stream.
        sb_on = 1'b0;
        run_until(ROT5, 300, 1'b0, slips, hit);
        chk("lock5_reached", 32'(hit), 32'd1);
        chk("lock5_slips",   32'(slips), 32'd5);
        chk("lock5_offset",  32'(o_offset), 32'd5);
        chk("lock5_state",   32'(o_state), 32'd4);
        sb_on = 1'b1; m_off = 5; m_last = PAT;
        i_mon_en = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b1, ROT5);
        step(1'b0, ROT5);

        // 3 bad then 1 good keeps lock; 4 consecutive bad drops it.
        for (int i = 0; i < 3; i++) step(1'b1, ROT5BAD);
        step(1'b1, ROT5);
        chk("loss3_locked", 32'(o_locked), 32'd1);
        chk("loss3_errcnt", 32'(o_err_cnt), 32'd3);
        for (int i = 0; i < 4; i++) step(1'b1, ROT5BAD);
        chk("loss4_state",  32'(o_state), 32'd3);
        chk("loss4_locked", 32'(o_locked), 32'd0);
        chk("loss4_errcnt", 32'(o_err_cnt), 32'd7);
        step(1'b1, ROT5);
        chk("loss_offset6", 32'(o_offset), 32'd6);
        chk("loss_settle",  32'(o_state), 32'd1);

        // Disable: IDLE, offset and error count retained.
        sb_on = 1'b0;
        i_en = 1'b0;
        step(1'b1, ROT15);
        chk("dis_state",  32'(o_state), 32'd0);
        chk("dis_offset", 32'(o_offset), 32'd6);
        chk("dis_errcnt", 32'(o_err_cnt), 32'd7);

        // Lock at offset 15, then force a slip that wraps to 0.
        i_en = 1'b1;
        run_until(ROT15, 300, 1'b0, slips, hit);
        chk("lock15_reached", 32'(hit), 32'd1);
        chk("lock15_slips",   32'(slips), 32'd9);
        chk("lock15_offset",  32'(o_offset), 32'd15);
        sb_on = 1'b1; m_off = 15; m_last = PAT;
        for (int i = 0; i < 3; i++) step(1'b1, ROT15);
        for (int i = 0; i < 4; i++) step(1'b1, PAT);
        chk("wrap_slip",   32'(o_state), 32'd3);
        chk("wrap_errcnt", 32'(o_err_cnt), 32'd11);
        step(1'b1, PAT);
        chk("wrap_offset0", 32'(o_offset), 32'd0);
        m_off = 0;
        run_until(PAT, 100, 1'b0, slips, hit);
        chk("lock0_reached", 32'(hit), 32'd1);
        chk("lock0_slips",   32'(slips), 32'd0);
        chk("lock0_offset",  32'(o_offset), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, PAT);

        // Nothing matches: full search of 16 offsets, then FAIL.
        sb_on = 1'b0;
        i_en = 1'b0;
        step(1'b1, NOMATCH);
        chk("fail_pre_idle", 32'(o_state), 32'd0);
        i_en = 1'b1;
        run_until(NOMATCH, 400, 1'b1, slips, hit);
        chk("fail_reached", 32'(hit), 32'd1);
        chk("fail_slips",   32'(slips), 32'd16);
        chk("fail_offset",  32'(o_offset), 32'd0);
        chk("fail_state",   32'(o_state), 32'd5);
        chk("fail_locked",  32'(o_locked), 32'd0);
        chk("fail_errcnt",  32'(o_err_cnt), 32'd11);
        for (int i = 0; i < 3; i++) step(1'b1, NOMATCH);
        chk("fail_hold", 32'(o_fail), 32'd1);
        i_en = 1'b0;
        step(1'b1, NOMATCH);
        chk("fail_exit_state", 32'(o_state), 32'd0);
        chk("fail_exit_fail",  32'(o_fail), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
